// File: rtl/config_loader_if.sv
// Bitstream word stream between the programming port (master) and the config loader (slave).
interface config_loader_if #(
  parameter int unsigned WORD_WIDTH = 8
);
  logic [WORD_WIDTH-1:0] bs_data;
  logic                  bs_valid;
  logic                  bs_ready;

  modport master (output bs_data, output bs_valid, input bs_ready);
  modport slave  (input bs_data, input bs_valid, output bs_ready);
endinterface

// File: rtl/config_loader.sv
// Serialises bitstream words LSB-first onto the fabric config chain, checks a trailing XOR
// checksum word and releases the fabric on a match.
module config_loader #(
  parameter int unsigned CONFIG_WIDTH = 17,
  parameter int unsigned WORD_WIDTH   = 8
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             start,
  config_loader_if.slave   bs,
  output logic             cfg_shift_data,
  output logic             cfg_shift_en,
  output logic             fabric_enable,
  output logic             done,
  output logic             error
);

  localparam int unsigned CntW = $clog2(CONFIG_WIDTH + 1);
  localparam int unsigned IdxW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CONFIG_WIDTH - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORD_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StShift, StCheck, StDone, StError} state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic                  full_q, full_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] csum_q, csum_d;

  logic accept;
  logic load_start;
  logic last_bit;
  logic word_end;

  assign last_bit = (cnt_q == LastCnt);
  assign word_end = (idx_q == LastIdx);

  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    full_d         = full_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    csum_d         = csum_q;
    bs.bs_ready    = 1'b0;
    cfg_shift_data = 1'b0;
    cfg_shift_en   = 1'b0;
    fabric_enable  = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    load_start     = 1'b0;
    accept         = 1'b0;

    unique case (state_q)
      StIdle: load_start = start;
      StShift: begin
        // Refill while the final needed bit of a word goes out, so streaming has no bubble.
        bs.bs_ready    = !full_q || (word_end && !last_bit);
        accept         = bs.bs_valid && bs.bs_ready;
        cfg_shift_en   = full_q;
        cfg_shift_data = full_q && word_q[idx_q];
        if (full_q) begin
          cnt_d = cnt_q + CntW'(1);
          idx_d = idx_q + IdxW'(1);
          if (last_bit) begin
            full_d  = 1'b0;
            state_d = StCheck;
          end else if (word_end) begin
            full_d = 1'b0;
          end
        end
        if (accept) begin
          word_d = bs.bs_data;
          full_d = 1'b1;
          idx_d  = '0;
          csum_d = csum_q ^ bs.bs_data;
        end
      end
      StCheck: begin
        bs.bs_ready = 1'b1;
        accept      = bs.bs_valid;
        if (accept) state_d = (bs.bs_data == csum_q) ? StDone : StError;
      end
      StDone: begin
        done          = 1'b1;
        fabric_enable = 1'b1;
        load_start    = start;
      end
      StError: begin
        error      = 1'b1;
        load_start = start;
      end
      default: state_d = StIdle;
    endcase

    if (load_start) begin
      state_d = StShift;
      full_d  = 1'b0;
      idx_d   = '0;
      cnt_d   = '0;
      csum_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q <= StIdle;
      word_q  <= '0;
      full_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      full_q  <= full_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Randomised and directed checks of config_loader against a word-list/bit-queue reference model.
module tb_config_loader;

  logic clock = 1'b0;
  logic nreset;
  logic start, start16;
  logic cfg_shift_data, cfg_shift_en, fabric_enable, done, error;
  logic data16, en16, fe16, done16, error16;

  int n_checks = 0;
  int n_fail   = 0;

  config_loader_if #(.WORD_WIDTH(8)) bif ();
  config_loader_if #(.WORD_WIDTH(8)) bif16 ();

  config_loader #(.CONFIG_WIDTH(17), .WORD_WIDTH(8)) dut (
    .clock          (clock),
    .nreset         (nreset),
    .start          (start),
    .bs             (bif),
    .cfg_shift_data (cfg_shift_data),
    .cfg_shift_en   (cfg_shift_en),
    .fabric_enable  (fabric_enable),
    .done           (done),
    .error          (error)
  );

  config_loader #(.CONFIG_WIDTH(16), .WORD_WIDTH(8)) dut16 (
    .clock          (clock),
    .nreset         (nreset),
    .start          (start16),
    .bs             (bif16),
    .cfg_shift_data (data16),
    .cfg_shift_en   (en16),
    .fabric_enable  (fe16),
    .done           (done16),
    .error          (error16)
  );

  always #5 clock = ~clock;

  bit got[$];
  always @(negedge clock) if (cfg_shift_en) got.push_back(cfg_shift_data);

  // Reference model: chain bits are the words' bits LSB-first truncated to the chain length.
  bit         exp_bits[$];
  logic [7:0] exp_cs;

  function automatic void build_model(input logic [7:0] words[$], input int cw);
    exp_bits.delete();
    exp_cs = 8'h00;
    foreach (words[i]) begin
      exp_cs ^= words[i];
      for (int b = 0; b < 8; b++) if (exp_bits.size() < cw) exp_bits.push_back(words[i][b]);
    end
  endfunction

  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] r = '0;
    foreach (q[i]) if (i < 32) r[i] = q[i];
    return r;
  endfunction

  task automatic start_pulse();
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] w);
    int n = 0;
    bif.bs_data  = w;
    bif.bs_valid = 1'b1;
    @(negedge clock);
    while (!bif.bs_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    n_checks++;
    if (!bif.bs_ready) begin
      n_fail++;
      $display("FAIL send_timeout: bs_ready=%b after %0d cycles, required 1", bif.bs_ready, n);
    end
    @(posedge clock); #1;
    bif.bs_valid = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] words[$], input logic [7:0] cs, input bit do_start,
                          input int max_gap);
    got.delete();
    if (do_start) start_pulse();
    foreach (words[i]) begin
      send(words[i]);
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) begin @(posedge clock); #1; end
    end
    send(cs);
    @(negedge clock);
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({bif.bs_ready, cfg_shift_data, cfg_shift_en, fabric_enable, done, error} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 000000",
               {bif.bs_ready, cfg_shift_data, cfg_shift_en, fabric_enable, done, error});
    end
    n_checks++;
    if ({bif16.bs_ready, en16, fe16, done16, error16} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs16: got %b, required 00000",
               {bif16.bs_ready, en16, fe16, done16, error16});
    end
    @(posedge clock); #1;
    nreset = 1'b1;
  endtask

  task automatic test_nominal();
    logic [7:0] w[$];
    w.push_back(8'hA5); w.push_back(8'h3C); w.push_back(8'h01);
    build_model(w, 17);
    run_load(w, 8'h98, 1'b1, 0);
    n_checks++;
    if (got.size() != 17) begin
      n_fail++; $display("FAIL nominal_pulses: got %0d, required 17", got.size());
    end
    n_checks++;
    if (pack(got) !== 32'h13CA5) begin
      n_fail++; $display("FAIL nominal_bits: got %h, required 13ca5", pack(got));
    end
    n_checks++;
    if ({done, fabric_enable, error} !== 3'b110) begin
      n_fail++; $display("FAIL nominal_status: got %b, required 110", {done, fabric_enable, error});
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] w[$];
    w.push_back(8'hA5); w.push_back(8'h3C); w.push_back(8'h01);
    build_model(w, 17);
    run_load(w, 8'h00, 1'b1, 0);
    n_checks++;
    if ({done, fabric_enable, error} !== 3'b001) begin
      n_fail++; $display("FAIL badcs_status: got %b, required 001", {done, fabric_enable, error});
    end
    start_pulse();
    n_checks++;
    if ({error, bif.bs_ready} !== 2'b01) begin
      n_fail++; $display("FAIL badcs_restart: error,ready=%b, required 01", {error, bif.bs_ready});
    end
    run_load(w, exp_cs, 1'b0, 0);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL badcs_reload_done: got %b, required 1", done);
    end
  endtask

  task automatic test_gap();
    logic [7:0] w[$];
    w.push_back(8'hA5); w.push_back(8'h3C); w.push_back(8'h01);
    build_model(w, 17);
    got.delete();
    start_pulse();
    send(8'hA5);
    repeat (8) begin @(posedge clock); #1; end
    repeat (5) begin
      @(negedge clock);
      n_checks++;
      if ({cfg_shift_en, bif.bs_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL gap_stall: en,ready=%b, required 01", {cfg_shift_en, bif.bs_ready});
      end
      @(posedge clock); #1;
    end
    send(8'h3C); send(8'h01); send(exp_cs);
    @(negedge clock);
    n_checks++;
    if (pack(got) !== pack(exp_bits) || got.size() != 17) begin
      n_fail++; $display("FAIL gap_bits: got %h (%0d), required %h (17)", pack(got), got.size(),
                         pack(exp_bits));
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL gap_done: got %b, required 1", done);
    end
  endtask

  task automatic test_no_bubble();
    logic [7:0] w16[3];
    logic [7:0] w[$];
    bit b16[$];
    int k = 0, pulses = 0, first = -1, last = -1;
    logic acc;
    w16[0] = 8'hA5; w16[1] = 8'h3C; w16[2] = 8'h99;
    w.push_back(w16[0]); w.push_back(w16[1]);
    build_model(w, 16);
    @(posedge clock); #1; start16 = 1'b1;
    @(posedge clock); #1; start16 = 1'b0;
    bif16.bs_data  = w16[0];
    bif16.bs_valid = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clock);
      if (en16) begin
        if (pulses == 7 || pulses == 15) begin
          n_checks++;
          if (bif16.bs_ready !== (pulses == 7)) begin
            n_fail++;
            $display("FAIL nobubble_ready_pulse%0d: got %b, required %b", pulses, bif16.bs_ready,
                     pulses == 7);
          end
        end
        b16.push_back(data16);
        if (first < 0) first = cyc;
        last = cyc;
        pulses++;
      end
      acc = bif16.bs_ready;
      @(posedge clock); #1;
      if (acc) begin
        k++;
        if (k < 3) bif16.bs_data = w16[k];
        else begin
          bif16.bs_valid = 1'b0;
          break;
        end
      end
    end
    bif16.bs_valid = 1'b0;
    @(negedge clock);
    n_checks++;
    if (pulses != 16 || last - first != 15) begin
      n_fail++; $display("FAIL nobubble_pulses: got %0d over span %0d, required 16 over 15",
                         pulses, last - first);
    end
    n_checks++;
    if (pack(b16) !== pack(exp_bits)) begin
      n_fail++; $display("FAIL nobubble_bits: got %h, required %h", pack(b16), pack(exp_bits));
    end
    n_checks++;
    if (done16 !== 1'b1) begin
      n_fail++; $display("FAIL nobubble_done: got %b, required 1", done16);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w[$];
    int n = 0;
    got.delete();
    start_pulse();
    send(8'hA5);
    send(8'h3C);
    while (got.size() < 9 && n < 50) begin @(negedge clock); #1; n++; end
    nreset = 1'b0;
    bif.bs_valid = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if ({bif.bs_ready, cfg_shift_data, cfg_shift_en, fabric_enable, done, error} !== 6'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got %b, required 000000",
                         {bif.bs_ready, cfg_shift_data, cfg_shift_en, fabric_enable, done, error});
    end
    nreset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (got.size() != 9 || bif.bs_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_idle: pulses=%0d ready=%b, required 9 and 0", got.size(),
                         bif.bs_ready);
    end
    w.push_back(8'h5A); w.push_back(8'hC3); w.push_back(8'h7E);
    build_model(w, 17);
    run_load(w, exp_cs, 1'b1, 0);
    n_checks++;
    if (done !== 1'b1 || pack(got) !== pack(exp_bits)) begin
      n_fail++; $display("FAIL midreset_reload: done=%b bits=%h, required 1 and %h", done,
                         pack(got), pack(exp_bits));
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] w[$];
    w.push_back(8'h12); w.push_back(8'hF0); w.push_back(8'h81);
    build_model(w, 17);
    got.delete();
    start_pulse();
    send(w[0]);
    start = 1'b1;
    send(w[1]);
    start = 1'b0;
    send(w[2]);
    send(exp_cs);
    @(negedge clock);
    n_checks++;
    if (got.size() != 17 || pack(got) !== pack(exp_bits) || done !== 1'b1) begin
      n_fail++; $display("FAIL startmid: pulses=%0d bits=%h done=%b, required 17 %h 1",
                         got.size(), pack(got), done, pack(exp_bits));
    end
    start_pulse();
    n_checks++;
    if ({fabric_enable, done, bif.bs_ready} !== 3'b001) begin
      n_fail++; $display("FAIL startdone: fe,done,ready=%b, required 001",
                         {fabric_enable, done, bif.bs_ready});
    end
    run_load(w, exp_cs, 1'b0, 0);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL startdone_reload: got %b, required 1", done);
    end
  endtask

  task automatic test_random();
    logic [7:0] w[$];
    logic [7:0] cs;
    bit good;
    for (int it = 0; it < 8; it++) begin
      w.delete();
      repeat (3) w.push_back(8'($urandom));
      build_model(w, 17);
      good = $urandom_range(1, 0) == 1;
      cs = good ? exp_cs : exp_cs ^ 8'($urandom_range(255, 1));
      run_load(w, cs, 1'b1, 3);
      n_checks++;
      if (got.size() != 17 || pack(got) !== pack(exp_bits)) begin
        n_fail++; $display("FAIL random%0d_bits: got %h (%0d), required %h (17)", it, pack(got),
                           got.size(), pack(exp_bits));
      end
      n_checks++;
      if ({done, fabric_enable, error} !== (good ? 3'b110 : 3'b001)) begin
        n_fail++; $display("FAIL random%0d_status: got %b, required %b", it,
                           {done, fabric_enable, error}, good ? 3'b110 : 3'b001);
      end
    end
  endtask

  initial begin
    start = 1'b0; start16 = 1'b0;
    bif.bs_data = '0;   bif.bs_valid = 1'b0;
    bif16.bs_data = '0; bif16.bs_valid = 1'b0;
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_gap();
    test_no_bubble();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
